// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
// Access-size codes, FSM state encoding, byte-enable patterns and the
// size decoder used by both the lane logic and the top-level control.
package lsu_pkg;

  // Access size/sign codes; stores reuse the low three codes
  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = OP_LB;
  localparam logic [3:0] OP_SH  = OP_LH;
  localparam logic [3:0] OP_SW  = OP_LW;

  // Byte-enable patterns before lane shifting
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Unsigned codes only exist for loads; any unknown code falls back to word
  function automatic lsu_size_e op_size(input logic [3:0] op, input logic is_store);
    lsu_size_e sz;
    sz = SZ_WORD;
    case (op)
      OP_LB:   sz = SZ_BYTE;
      OP_LH:   sz = SZ_HALF;
      OP_LBU:  if (!is_store) sz = SZ_BYTE;
      OP_LHU:  if (!is_store) sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Store side: effective offset, byte enables and lane-replicated write data.
// Load side: byte/halfword extraction and sign/zero extension of the bus word.
// LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses are flagged;
// otherwise the low address bits below the access size are cleared.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic [1:0]  off_o,
  output logic        misalign_o,
  input  logic [3:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  lsu_size_e req_size;
  lsu_size_e ld_size;
  logic      ld_signed;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_size  = op_size(op_i, is_store_i);
  assign ld_size   = op_size(ld_op_i, 1'b0);
  assign ld_signed = (ld_op_i == OP_LB) || (ld_op_i == OP_LH);

  // Effective byte offset of the incoming access and its misalign flag
  always_comb begin
    off_o      = addr_lo_i;
    misalign_o = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_o = ((req_size == SZ_HALF) && addr_lo_i[0]) ||
                 ((req_size == SZ_WORD) && (addr_lo_i != 2'b00));
`else
    case (req_size)
      SZ_HALF: off_o = {addr_lo_i[1], 1'b0};
      SZ_WORD: off_o = 2'b00;
      default: off_o = addr_lo_i;
    endcase
`endif
  end

  // Store byte enables and replicated write data for the selected lanes
  always_comb begin
    st_be_o    = BE_WORD;
    st_wdata_o = st_data_i;
    case (req_size)
      SZ_BYTE: begin
        st_be_o    = BE_BYTE << off_o;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o    = BE_HALF << {off_o[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = BE_WORD;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Pick the addressed byte/halfword of the read word and extend it
  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_size)
      SZ_BYTE: ld_data_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a single-outstanding data bus.
// Stalls the pipeline from access acceptance until the bus acknowledges,
// then returns extended load data with a one-cycle valid strobe.
// LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses raise misalign_o
// and are not issued; otherwise they are silently aligned down.
module mem_lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  input  logic [3:0]  ld_op_i,
  input  logic        mem_wren_i,
  input  logic        is_load_i,
  output logic        stall_o,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        is_ld_q, is_ld_d;
  logic [3:0]  ld_op_q, ld_op_d;
  logic [1:0]  ld_off_q, ld_off_d;

  logic        pending;
  logic        go;
  logic        mis_raw;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [1:0]  eff_off;
  logic [31:0] ld_ext;

  lsu_align u_align (
    .op_i       (ld_op_i),
    .addr_lo_i  (addr_i[1:0]),
    .is_store_i (mem_wren_i),
    .st_data_i  (st_data_i),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .off_o      (eff_off),
    .misalign_o (mis_raw),
    .ld_op_i    (ld_op_q),
    .ld_off_i   (ld_off_q),
    .rdata_i    (bus_rdata_i),
    .ld_data_o  (ld_ext)
  );

  assign pending = is_load_i | mem_wren_i;
  assign go      = (state_q == ST_IDLE) && pending && !mis_raw;

  // Stall and misalign are combinational so the pipeline freezes in the accept cycle
  always_comb begin
    stall_o    = !rst_i && (go || (state_q == ST_REQ));
    misalign_o = !rst_i && (state_q == ST_IDLE) && pending && mis_raw;
  end

  // Next-state and registered-output logic of the IDLE/REQ/DONE handshake
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ld_data_d   = ld_data_q;
    ld_valid_d  = 1'b0;
    is_ld_d     = is_ld_q;
    ld_op_d     = ld_op_q;
    ld_off_d    = ld_off_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d     = ST_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_wren_i;
          bus_addr_d  = {addr_i[31:2], 2'b00};
          bus_be_d    = mem_wren_i ? st_be : BE_WORD;
          bus_wdata_d = mem_wren_i ? st_wdata : 32'h0;
          is_ld_d     = !mem_wren_i;
          ld_op_d     = ld_op_i;
          ld_off_d    = eff_off;
        end
      end
      ST_REQ: begin
        if (bus_ack_i) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          if (is_ld_q) begin
            ld_data_d  = ld_ext;
            ld_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      ld_data_q   <= 32'h0;
      ld_valid_q  <= 1'b0;
      is_ld_q     <= 1'b0;
      ld_op_q     <= 4'h0;
      ld_off_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      ld_data_q   <= ld_data_d;
      ld_valid_q  <= ld_valid_d;
      is_ld_q     <= is_ld_d;
      ld_op_q     <= ld_op_d;
      ld_off_q    <= ld_off_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign ld_data_o   = ld_data_q;
  assign ld_valid_o  = ld_valid_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu.
// Directed vector table plus randomized accesses, checked against an
// arithmetic reference model. Honors LSU_MISALIGN_TRAP_EN when defined.
module tb_mem_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  ld_op_i;
  logic        mem_wren_i;
  logic        is_load_i;
  logic        stall_o;
  logic [31:0] ld_data_o;
  logic        ld_valid_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int tests_run;
  int tests_failed;
  logic [31:0] last_ld;

  typedef struct {
    logic        is_ld;
    logic        is_st;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t tbl[11];

  mem_lsu dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .addr_i      (addr_i),
    .st_data_i   (st_data_i),
    .ld_op_i     (ld_op_i),
    .mem_wren_i  (mem_wren_i),
    .is_load_i   (is_load_i),
    .stall_o     (stall_o),
    .ld_data_o   (ld_data_o),
    .ld_valid_o  (ld_valid_o),
    .misalign_o  (misalign_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Safety net in case the DUT wedges the bench
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic ld, input logic st_en, input logic [3:0] op,
                              input logic [31:0] addr, input logic [31:0] st,
                              input logic [31:0] rdata, input int waits,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] eld);
    vec_t v;
    v.is_ld = ld; v.is_st = st_en; v.op = op; v.addr = addr; v.st = st;
    v.rdata = rdata; v.waits = waits; v.exp_addr = ea; v.exp_be = ebe;
    v.exp_wdata = ewd; v.exp_ld = eld;
    return v;
  endfunction

  // Access size in bytes from the op code and direction
  function automatic int sizeOf(input logic [3:0] op, input logic is_st);
    if (is_st) return (op == 4'd0) ? 1 : (op == 4'd1) ? 2 : 4;
    if (op == 4'd0 || op == 4'd4) return 1;
    if (op == 4'd1 || op == 4'd5) return 2;
    return 4;
  endfunction

  function automatic logic modelMisalign(input vec_t v);
`ifdef LSU_MISALIGN_TRAP_EN
    int sz;
    if (!(v.is_ld || v.is_st)) return 1'b0;
    sz = sizeOf(v.op, v.is_st);
    return (v.addr % sz) != 0;
`else
    return 1'b0 & v.is_ld;
`endif
  endfunction

  // Reference model: expected bus fields and load result from plain arithmetic
  function automatic vec_t modelExpect(input vec_t v);
    vec_t r;
    int sz;
    logic [31:0] part;
    r = v;
    sz = sizeOf(v.op, v.is_st);
    r.exp_addr = v.addr - (v.addr % 4);
    if (v.is_st) begin
      if (sz == 1) begin
        r.exp_be    = 4'(1 << (v.addr % 4));
        r.exp_wdata = (v.st % 256) * 32'h0101_0101;
      end else if (sz == 2) begin
        r.exp_be    = 4'(3 << (2 * ((v.addr / 2) % 2)));
        r.exp_wdata = (v.st % 65536) * 32'h0001_0001;
      end else begin
        r.exp_be    = 4'hF;
        r.exp_wdata = v.st;
      end
      r.exp_ld = 32'h0;
    end else begin
      r.exp_be    = 4'hF;
      r.exp_wdata = 32'h0;
      if (sz == 1) begin
        part = (v.rdata >> (8 * (v.addr % 4))) % 256;
        if (v.op == 4'd0 && part >= 128) part = part + 32'hFFFF_FF00;
      end else if (sz == 2) begin
        part = (v.rdata >> (16 * ((v.addr / 2) % 2))) % 65536;
        if (v.op == 4'd1 && part >= 32768) part = part + 32'hFFFF_0000;
      end else begin
        part = v.rdata;
      end
      r.exp_ld = part;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle with no access pending; optionally a stray ack
  task automatic idleCycle(input logic stray_ack);
    @(negedge clk_i);
    is_load_i = 1'b0; mem_wren_i = 1'b0; bus_ack_i = stray_ack;
    bus_rdata_i = $urandom;
    addr_i = $urandom; ld_op_i = 4'($urandom); st_data_i = $urandom;
    #1;
    checkOutput("idle stall", 32'(stall_o), 32'd0);
    checkOutput("idle misalign", 32'(misalign_o), 32'd0);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    #1;
    checkOutput("idle req", 32'(bus_req_o), 32'd0);
    checkOutput("idle ld_valid", 32'(ld_valid_o), 32'd0);
    checkOutput("idle ld_data hold", ld_data_o, last_ld);
  endtask

  // Issue one access, act as the bus slave, and check every cycle of it
  task automatic applyStimulus(input vec_t v);
    logic mis;
    @(negedge clk_i);
    is_load_i = v.is_ld; mem_wren_i = v.is_st; ld_op_i = v.op;
    addr_i = v.addr; st_data_i = v.st; bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    #1;
    mis = modelMisalign(v);
    checkOutput("misalign", 32'(misalign_o), 32'(mis));
    checkOutput("ld_valid at issue", 32'(ld_valid_o), 32'd0);
    if (mis) begin
      checkOutput("stall on trap", 32'(stall_o), 32'd0);
      @(negedge clk_i);
      is_load_i = 1'b0; mem_wren_i = 1'b0;
      #1;
      checkOutput("req after trap", 32'(bus_req_o), 32'd0);
      checkOutput("ld_valid after trap", 32'(ld_valid_o), 32'd0);
      checkOutput("stall after trap", 32'(stall_o), 32'd0);
    end else begin
      checkOutput("stall at issue", 32'(stall_o), 32'd1);
      checkOutput("req at issue", 32'(bus_req_o), 32'd0);
      for (int c = 0; c <= v.waits; c++) begin
        @(negedge clk_i);
        #1;
        checkOutput("req in wait", 32'(bus_req_o), 32'd1);
        checkOutput("stall in wait", 32'(stall_o), 32'd1);
        checkOutput("bus_addr", bus_addr_o, v.exp_addr);
        checkOutput("bus_we", 32'(bus_we_o), 32'(v.is_st));
        checkOutput("bus_be", 32'(bus_be_o), 32'(v.exp_be));
        if (v.is_st) checkOutput("bus_wdata", bus_wdata_o, v.exp_wdata);
        if (c == v.waits) begin
          bus_ack_i = 1'b1; bus_rdata_i = v.rdata;
        end else begin
          bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        end
      end
      @(negedge clk_i);
      bus_ack_i = 1'b0; bus_rdata_i = $urandom;
      #1;
      checkOutput("stall at done", 32'(stall_o), 32'd0);
      checkOutput("req at done", 32'(bus_req_o), 32'd0);
      checkOutput("ld_valid at done", 32'(ld_valid_o), 32'(v.is_ld && !v.is_st));
      if (v.is_ld && !v.is_st) last_ld = v.exp_ld;
      checkOutput("ld_data", ld_data_o, last_ld);
    end
  endtask

  initial begin
    vec_t v;
    int kind;
    logic [3:0] ld_ops[7];
    logic [3:0] st_ops[4];
    ld_ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd3, 4'd15};
    st_ops = '{4'd0, 4'd1, 4'd2, 4'd11};
    tests_run = 0; tests_failed = 0; last_ld = 32'h0;

    //           ld    st    op     addr          st_data       rdata        wt  exp_addr      be     wdata         ld
    tbl[0]  = mk(1'b1, 1'b0, 4'd2, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 32'h0000_0100, 4'hF, 32'h0,        32'hDEADBEEF);
    tbl[1]  = mk(1'b1, 1'b0, 4'd0, 32'h0000_0103, 32'h0,        32'h80123456, 0, 32'h0000_0100, 4'hF, 32'h0,        32'hFFFFFF80);
    tbl[2]  = mk(1'b1, 1'b0, 4'd4, 32'h0000_0103, 32'h0,        32'h80123456, 1, 32'h0000_0100, 4'hF, 32'h0,        32'h00000080);
    tbl[3]  = mk(1'b0, 1'b1, 4'd1, 32'h0000_0102, 32'h0000ABCD, 32'h0,        0, 32'h0000_0100, 4'hC, 32'hABCDABCD, 32'h0);
    tbl[4]  = mk(1'b1, 1'b0, 4'd2, 32'h0000_0200, 32'h0,        32'h12345678, 3, 32'h0000_0200, 4'hF, 32'h0,        32'h12345678);
    tbl[5]  = mk(1'b0, 1'b1, 4'd0, 32'h0000_0205, 32'h0000005A, 32'h0,        2, 32'h0000_0204, 4'h2, 32'h5A5A5A5A, 32'h0);
    tbl[6]  = mk(1'b1, 1'b0, 4'd1, 32'h0000_0106, 32'h0,        32'h80017FFF, 0, 32'h0000_0104, 4'hF, 32'h0,        32'hFFFF8001);
    tbl[7]  = mk(1'b1, 1'b0, 4'd5, 32'h0000_0104, 32'h0,        32'h1234F00D, 1, 32'h0000_0104, 4'hF, 32'h0,        32'h0000F00D);
    tbl[8]  = mk(1'b0, 1'b1, 4'd2, 32'h0000_0300, 32'hCAFEF00D, 32'h0,        0, 32'h0000_0300, 4'hF, 32'hCAFEF00D, 32'h0);
    tbl[9]  = mk(1'b1, 1'b1, 4'd2, 32'h0000_0040, 32'h01020304, 32'h0,        1, 32'h0000_0040, 4'hF, 32'h01020304, 32'h0);
    tbl[10] = mk(1'b1, 1'b0, 4'd2, 32'h0000_0102, 32'h0,        32'h11223344, 0, 32'h0000_0100, 4'hF, 32'h0,        32'h11223344);

    rst_i = 1'b1; is_load_i = 1'b0; mem_wren_i = 1'b0; ld_op_i = 4'h0;
    addr_i = 32'h0; st_data_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    checkOutput("reset ld_data", ld_data_o, 32'h0);
    checkOutput("reset ld_valid", 32'(ld_valid_o), 32'd0);
    checkOutput("reset misalign", 32'(misalign_o), 32'd0);
    checkOutput("reset req", 32'(bus_req_o), 32'd0);
    checkOutput("reset we", 32'(bus_we_o), 32'd0);
    checkOutput("reset addr", bus_addr_o, 32'h0);
    checkOutput("reset be", 32'(bus_be_o), 32'd0);
    checkOutput("reset wdata", bus_wdata_o, 32'h0);
    rst_i = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 11; i++) applyStimulus(tbl[i]);

    $display("[TB] stray ack while idle");
    idleCycle(1'b1);

    $display("[TB] reset during REQ");
    @(negedge clk_i);
    is_load_i = 1'b1; mem_wren_i = 1'b0; ld_op_i = 4'd2; addr_i = 32'h0000_0080;
    #1;
    checkOutput("rst seq stall", 32'(stall_o), 32'd1);
    @(negedge clk_i);
    #1;
    checkOutput("rst seq req", 32'(bus_req_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; is_load_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    #1;
    checkOutput("rst seq req dropped", 32'(bus_req_o), 32'd0);
    checkOutput("rst seq stall dropped", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    #1;
    checkOutput("rst seq ld_valid", 32'(ld_valid_o), 32'd0);
    checkOutput("rst seq req after ack", 32'(bus_req_o), 32'd0);
    checkOutput("rst seq ld_data", ld_data_o, 32'h0);
    last_ld = 32'h0;
    applyStimulus(tbl[0]);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 1));
      v.is_ld = (kind == 0);
      v.is_st = (kind == 1);
      if (v.is_st) begin
        v.op = st_ops[$urandom_range(0, 3)];
        if ($urandom_range(0, 5) == 0) v.is_ld = 1'b1;
      end else begin
        v.op = ld_ops[$urandom_range(0, 6)];
      end
      v.addr  = $urandom;
      v.st    = $urandom;
      v.rdata = $urandom;
      v.waits = int'($urandom_range(0, 3));
      v = modelExpect(v);
      applyStimulus(v);
      if ($urandom_range(0, 2) == 0) idleCycle(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
